regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
Controller for the 32x64 integer register file's single write port.
- Arbitrates two writeback requesters onto that port: A (ALU pipe) and B (load/multi-cycle unit).
- Registers the selected write, then drives the port's RegWrite/rd/write_data inputs.
- Keeps a per-register pending scoreboard that stalls decode on RAW/WAW hazards until the destination write has landed.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles B may be kept waiting by A before B is forced to win one grant.
- XLEN, 64, data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction issued this cycle with a destination register
- issue_rd  in  5  destination of the issuing instruction
- chk_rs1  in  5  decode source 1 to check
- chk_rs2  in  5  decode source 2 to check
- chk_rd  in  5  decode destination to check (WAW)
- stall  out  1  hazard: one of chk_rs1/chk_rs2/chk_rd is pending
- a_valid  in  1  requester A has a write
- a_rd  in  5  requester A destination
- a_data  in  XLEN  requester A data
- a_ready  out  1  requester A granted this cycle
- b_valid  in  1  requester B has a write
- b_rd  in  5  requester B destination
- b_data  in  XLEN  requester B data
- b_ready  out  1  requester B granted this cycle
- wb_we  out  1  to register file RegWrite
- wb_rd  out  5  to register file rd
- wb_data  out  XLEN  to register file write_data
- pending_o  out  32  scoreboard bits, for debug and verification

Behaviour:
- Reset (sync, rst=1 at posedge):
  - pending=0, wb_we=0, wb_rd=0, wb_data=0, starve_cnt=0.
  - Reset mid-operation discards any registered write and all pending bits.
- Arbitration is combinational in the request cycle:
  - Grant goes to A if a_valid, unless starve_cnt==STARVE_LIMIT and b_valid; then B wins.
  - Otherwise B is granted if b_valid.
  - a_ready/b_ready are the one-hot grant, never both high.
  - A transfer happens when valid && ready. A requester holds valid/rd/data stable until ready.
- starve_cnt:
  - Increments when b_valid and B is not granted.
  - Resets to 0 when B is granted or b_valid=0.
  - Saturates at STARVE_LIMIT.
- Write register:
  - On a granted transfer, wb_we<=1, wb_rd<=granted rd, wb_data<=granted data.
  - With no grant, wb_we<=0; wb_rd and wb_data hold.
  - Latency is request-to-port 1 cycle; the register file commits at the following edge.
- Writes to x0:
  - Granted and acknowledged normally. wb_we is forced to 0 when the granted rd==0.
  - The scoreboard never sets bit 0.
- Scoreboard, per register bit r:
  - set = issue_valid && issue_rd==r && r!=0
  - clr = wb_we && wb_rd==r
  - next = set ? 1 : (clr ? 0 : pending[r]); when set and clr coincide on the same r, set wins.
  - Clearing in the wb_we cycle aligns with the register-file write edge, so stall drops exactly when the new value is readable.
- stall = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]. Combinational; bit 0 is always 0.
- Issue to an already-pending rd leaves the bit set. This is a single bit, not a counter; decode's WAW stall prevents it in legal flows.
- Back-to-back grants with no bubble are allowed, giving one write per cycle sustained.
- Both requesters targeting the same rd in the same cycle are serialized by arbitration order; no merging.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5
  - NUM_REGS=32
  - XLEN=64
  - requester index constants REQ_A=0, REQ_B=1
- One natural sub-module: wb_arbiter_2to1. It holds the fixed priority, the starvation counter and the grant outputs.
- The scoreboard bit-vector and the write register stay in the top.

Test Plan:
- Reset: hold rst 2 cycles mid-traffic -> wb_we=0, pending_o=0, stall=0, a_ready=b_ready=0 with no valids.
- Single write: issue_valid with issue_rd=5, then a_valid with a_rd=5, a_data=0xDEAD -> pending_o[5]=1, stall=1 for chk_rs1=5. The grant cycle is followed by wb_we=1, wb_rd=5, wb_data=0xDEAD. pending_o[5]=0 and stall=0 one cycle later.
- Priority and starvation: a_valid and b_valid held continuously, STARVE_LIMIT=4 -> grants A,A,A,A,B,A,A,A,A,B… and starve_cnt returns to 0 after each B grant.
- x0: a_valid with a_rd=0, data=0xFF; issue_rd=0 -> a_ready=1, wb_we stays 0, pending_o[0] stays 0.
- Set/clear collision: wb_we=1 with wb_rd=7 in the same cycle as issue_valid with issue_rd=7 -> pending_o[7] stays 1.
- Back-to-back: B writes x3, x4, x5 on consecutive cycles with A idle -> wb_we high 3 consecutive cycles with matching rd and data. Bits 3, 4, 5 clear in order.

Source files
------------

// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared constants and types for the register-file writeback controller.
// Register-address width, register count, data width and requester indices.
package regfile_wb_scoreboard_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned XLEN       = 64;

   // Requester slots on the 2:1 writeback arbiter
   localparam int unsigned REQ_A = 0;
   localparam int unsigned REQ_B = 1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_A    = 2'b01,
      GNT_B    = 2'b10
   } grant_e;

endpackage

// File: rtl/regfile_wb_scoreboard_arbiter.sv
// Two-requester writeback arbiter: A has fixed priority, B is guaranteed a grant
// after STARVE_LIMIT consecutive cycles of waiting.
module wb_arbiter_2to1
   import regfile_wb_scoreboard_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   i_valid,
   output logic [1:0]   o_ready,
   output grant_e       o_grant
);

   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] r_starve_cnt;
   logic             w_starved;
   grant_e           w_grant;

   assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

   always_comb begin
      w_grant = GNT_NONE;
      if (i_valid[REQ_A] && !(w_starved && i_valid[REQ_B])) begin
         w_grant = GNT_A;
      end else if (i_valid[REQ_B]) begin
         w_grant = GNT_B;
      end
   end

   // Counts cycles B waits behind A; saturates so B wins on the limit cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (!i_valid[REQ_B] || (w_grant == GNT_B)) begin
         r_starve_cnt <= '0;
      end else if (!w_starved) begin
         r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      o_ready        = '0;
      o_ready[REQ_A] = (w_grant == GNT_A);
      o_ready[REQ_B] = (w_grant == GNT_B);
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write-port controller: arbitrates A/B writebacks into one registered
// write and tracks per-register pending bits to stall decode on RAW/WAW hazards.
module regfile_wb_scoreboard #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned XLEN         = regfile_wb_scoreboard_pkg::XLEN
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          issue_valid,
   input  logic [regfile_wb_scoreboard_pkg::REG_ADDR_W-1:0] issue_rd,
   input  logic [regfile_wb_scoreboard_pkg::REG_ADDR_W-1:0] chk_rs1,
   input  logic [regfile_wb_scoreboard_pkg::REG_ADDR_W-1:0] chk_rs2,
   input  logic [regfile_wb_scoreboard_pkg::REG_ADDR_W-1:0] chk_rd,
   output logic                                          stall,
   input  logic                                          a_valid,
   input  logic [regfile_wb_scoreboard_pkg::REG_ADDR_W-1:0] a_rd,
   input  logic [XLEN-1:0]                               a_data,
   output logic                                          a_ready,
   input  logic                                          b_valid,
   input  logic [regfile_wb_scoreboard_pkg::REG_ADDR_W-1:0] b_rd,
   input  logic [XLEN-1:0]                               b_data,
   output logic                                          b_ready,
   output logic                                          wb_we,
   output logic [regfile_wb_scoreboard_pkg::REG_ADDR_W-1:0] wb_rd,
   output logic [XLEN-1:0]                               wb_data,
   output logic [regfile_wb_scoreboard_pkg::NUM_REGS-1:0]   pending_o
);

   import regfile_wb_scoreboard_pkg::*;

   logic [1:0]          w_req_valid;
   logic [1:0]          w_req_ready;
   grant_e              w_grant;
   logic                w_xfer;
   reg_addr_t           w_sel_rd;
   logic [XLEN-1:0]     w_sel_data;

   logic                r_wb_we;
   reg_addr_t           r_wb_rd;
   logic [XLEN-1:0]     r_wb_data;

   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;
   logic [NUM_REGS-1:0] w_pending_nxt;

   always_comb begin
      w_req_valid        = '0;
      w_req_valid[REQ_A] = a_valid;
      w_req_valid[REQ_B] = b_valid;
   end

   wb_arbiter_2to1 #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_req_valid),
      .o_ready (w_req_ready),
      .o_grant (w_grant)
   );

   assign a_ready = w_req_ready[REQ_A];
   assign b_ready = w_req_ready[REQ_B];

   always_comb begin
      w_xfer     = 1'b0;
      w_sel_rd   = a_rd;
      w_sel_data = a_data;
      unique case (w_grant)
         GNT_A: begin
            w_xfer     = 1'b1;
            w_sel_rd   = a_rd;
            w_sel_data = a_data;
         end
         GNT_B: begin
            w_xfer     = 1'b1;
            w_sel_rd   = b_rd;
            w_sel_data = b_data;
         end
         default: begin
            w_xfer = 1'b0;
         end
      endcase
   end

   // x0 writes are acknowledged and captured but never reach the register file
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_we   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else if (w_xfer) begin
         r_wb_we   <= (w_sel_rd != '0);
         r_wb_rd   <= w_sel_rd;
         r_wb_data <= w_sel_data;
      end else begin
         r_wb_we   <= 1'b0;
      end
   end

   assign wb_we   = r_wb_we;
   assign wb_rd   = r_wb_rd;
   assign wb_data = r_wb_data;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         w_set[r] = issue_valid && (issue_rd == REG_ADDR_W'(r));
         w_clr[r] = r_wb_we && (r_wb_rd == REG_ADDR_W'(r));
      end
   end

   // Set dominates clear so a reissue in the landing cycle stays pending
   always_comb begin
      w_pending_nxt    = (r_pending & ~w_clr) | w_set;
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   assign pending_o = r_pending;
   assign stall     = r_pending[chk_rs1] | r_pending[chk_rs2] | r_pending[chk_rd];

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench: stimulus queues expected register-file writes, a negedge monitor
// pops and compares them whenever wb_we is presented.
module tb_regfile_wb_scoreboard;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic [4:0]  chk_rd;
   logic        stall;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [63:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_rd;
   logic [63:0] b_data;
   logic        b_ready;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic [31:0] pending_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   regfile_wb_scoreboard #(
      .STARVE_LIMIT (4),
      .XLEN         (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .chk_rs1     (chk_rs1),
      .chk_rs2     (chk_rs2),
      .chk_rd      (chk_rd),
      .stall       (stall),
      .a_valid     (a_valid),
      .a_rd        (a_rd),
      .a_data      (a_data),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_rd        (b_rd),
      .b_data      (b_data),
      .b_ready     (b_ready),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .pending_o   (pending_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      issue_rd    = '0;
      a_valid     = 1'b0;
      a_rd        = '0;
      a_data      = '0;
      b_valid     = 1'b0;
      b_rd        = '0;
      b_data      = '0;
   endtask

   task automatic push(input logic [4:0] rd, input logic [63:0] data);
      exp_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: every presented register-file write must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (wb_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no write at %0t",
                     wb_rd, wb_data, $time);
         end else begin
            e = exp_q.pop_front();
            chk("wb_rd", 64'(wb_rd), 64'(e.rd));
            chk("wb_data", wb_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ai;
      int bi;
      logic exp_b;
      rst = 1'b1;
      chk_rs1 = '0;
      chk_rs2 = '0;
      chk_rd  = '0;
      idle();

      // Power-on reset
      nxt();
      nxt();
      rst = 1'b0;
      chk_rs1 = 5'd5;
      settle();
      chk("rst_wb_we", 64'(wb_we), 64'd0);
      chk("rst_pending", 64'(pending_o), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd0);

      // Single write: issue x5, then A writes 0xDEAD to x5
      nxt();
      issue_valid = 1'b1;
      issue_rd    = 5'd5;
      nxt();
      idle();
      a_valid = 1'b1;
      a_rd    = 5'd5;
      a_data  = 64'hDEAD;
      settle();
      chk("sw_pending5", 64'(pending_o[5]), 64'd1);
      chk("sw_stall", 64'(stall), 64'd1);
      chk("sw_a_ready", 64'(a_ready), 64'd1);
      chk("sw_b_ready", 64'(b_ready), 64'd0);
      push(5'd5, 64'hDEAD);
      nxt();
      idle();
      settle();
      chk("sw_wb_we", 64'(wb_we), 64'd1);
      chk("sw_stall_wbcycle", 64'(stall), 64'd1);
      nxt();
      settle();
      chk("sw_pending5_clr", 64'(pending_o[5]), 64'd0);
      chk("sw_stall_clr", 64'(stall), 64'd0);
      chk_rs1 = '0;

      // Priority and starvation: both held valid, B must win every fifth cycle
      ai = 0;
      bi = 0;
      for (int i = 0; i < 10; i++) begin
         nxt();
         a_valid = 1'b1;
         a_rd    = 5'(ai + 1);
         a_data  = 64'hA00 + 64'(ai);
         b_valid = 1'b1;
         b_rd    = 5'(20 + bi);
         b_data  = 64'hB00 + 64'(bi);
         settle();
         exp_b = ((i % 5) == 4);
         chk("starve_a_ready", 64'(a_ready), 64'(!exp_b));
         chk("starve_b_ready", 64'(b_ready), 64'(exp_b));
         if (exp_b) begin
            push(b_rd, b_data);
            bi++;
         end else begin
            push(a_rd, a_data);
            ai++;
         end
      end
      nxt();
      idle();
      nxt();

      // x0: acknowledged, never written, never pending
      nxt();
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      a_valid     = 1'b1;
      a_rd        = 5'd0;
      a_data      = 64'hFF;
      settle();
      chk("x0_a_ready", 64'(a_ready), 64'd1);
      nxt();
      idle();
      settle();
      chk("x0_wb_we", 64'(wb_we), 64'd0);
      chk("x0_pending0", 64'(pending_o[0]), 64'd0);
      nxt();
      settle();
      chk("x0_wb_we_later", 64'(wb_we), 64'd0);

      // Set/clear collision on x7
      nxt();
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      a_valid     = 1'b1;
      a_rd        = 5'd7;
      a_data      = 64'h77;
      settle();
      push(5'd7, 64'h77);
      nxt();
      idle();
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      settle();
      chk("col_pending7_a", 64'(pending_o[7]), 64'd1);
      chk("col_wb_we", 64'(wb_we), 64'd1);
      nxt();
      idle();
      a_valid = 1'b1;
      a_rd    = 5'd7;
      a_data  = 64'h78;
      settle();
      chk("col_pending7_kept", 64'(pending_o[7]), 64'd1);
      push(5'd7, 64'h78);
      nxt();
      idle();
      nxt();
      settle();
      chk("col_pending7_clr", 64'(pending_o[7]), 64'd0);

      // Back-to-back: B writes x3, x4, x5 on consecutive cycles
      for (int r = 3; r <= 5; r++) begin
         nxt();
         idle();
         issue_valid = 1'b1;
         issue_rd    = 5'(r);
      end
      chk_rd = 5'd4;
      for (int r = 3; r <= 5; r++) begin
         nxt();
         idle();
         b_valid = 1'b1;
         b_rd    = 5'(r);
         b_data  = 64'(r) * 64'h11;
         settle();
         chk("b2b_b_ready", 64'(b_ready), 64'd1);
         push(b_rd, b_data);
         case (r)
            3: begin
               chk("b2b_pend_c0", 64'(pending_o[5:3]), 64'b111);
               chk("b2b_we_c0", 64'(wb_we), 64'd0);
            end
            4: begin
               chk("b2b_pend_c1", 64'(pending_o[5:3]), 64'b111);
               chk("b2b_we_c1", 64'(wb_we), 64'd1);
            end
            default: begin
               chk("b2b_pend_c2", 64'(pending_o[5:3]), 64'b110);
               chk("b2b_we_c2", 64'(wb_we), 64'd1);
               chk("b2b_waw_stall", 64'(stall), 64'd1);
            end
         endcase
      end
      nxt();
      idle();
      settle();
      chk("b2b_pend_c3", 64'(pending_o[5:3]), 64'b100);
      chk("b2b_we_c3", 64'(wb_we), 64'd1);
      chk("b2b_waw_stall_clr", 64'(stall), 64'd0);
      nxt();
      settle();
      chk("b2b_pend_c4", 64'(pending_o[5:3]), 64'b000);
      chk("b2b_we_c4", 64'(wb_we), 64'd0);
      chk_rd = '0;

      // Reset mid-traffic: pending bits and the in-flight write are discarded
      nxt();
      issue_valid = 1'b1;
      issue_rd    = 5'd10;
      a_valid     = 1'b1;
      a_rd        = 5'd12;
      a_data      = 64'h1212;
      settle();
      push(5'd12, 64'h1212);
      nxt();
      rst         = 1'b1;
      issue_valid = 1'b1;
      issue_rd    = 5'd11;
      a_valid     = 1'b1;
      a_rd        = 5'd13;
      a_data      = 64'h1313;
      settle();
      chk("mr_pending10_pre", 64'(pending_o[10]), 64'd1);
      nxt();
      idle();
      b_valid = 1'b1;
      b_rd    = 5'd14;
      b_data  = 64'h1414;
      nxt();
      rst = 1'b0;
      idle();
      chk_rs1 = 5'd10;
      chk_rs2 = 5'd11;
      chk_rd  = 5'd12;
      settle();
      chk("mr_wb_we", 64'(wb_we), 64'd0);
      chk("mr_pending", 64'(pending_o), 64'd0);
      chk("mr_stall", 64'(stall), 64'd0);
      chk("mr_a_ready", 64'(a_ready), 64'd0);
      chk("mr_b_ready", 64'(b_ready), 64'd0);
      nxt();
      settle();
      chk("mr_wb_we_after", 64'(wb_we), 64'd0);

      nxt();
      nxt();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
